// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage of the 5-stage ARM core: forwards ALU results into MEM/WB and runs each
// LDR/STR as two 16-bit SRAM half-word accesses, freezing the upstream pipeline meanwhile.
module mem_stage_sram_ctrl #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned WAIT_CYC  = 2,
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       alu_res_in,
    input  logic [31:0]       val_rm_in,
    input  logic [3:0]        dest_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    output logic              freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_wdata,
    input  logic [15:0]       sram_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic [31:0]       alu_res_out,
    output logic [31:0]       mem_data_out,
    output logic [3:0]        dest_out
);

    localparam int unsigned      CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       rd_lo_q, rd_lo_d;
    logic [15:0]       rd_hi_q, rd_hi_d;

    logic              wb_en_q, wb_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic [31:0]       alu_res_q, alu_res_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [3:0]        dest_q, dest_d;

    logic              mem_op;
    logic              is_store;
    logic              phase_last;
    logic [31:0]       off;
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;

    assign mem_op     = mem_r_en_in | mem_w_en_in;
    // A request with both enables set is a load; it must never write.
    assign is_store   = mem_w_en_in & ~mem_r_en_in;
    assign phase_last = (cnt_q == CNT_LAST);
    assign freeze     = mem_op & (state_q != ST_DONE);

    // Word-aligned half-word pair; out-of-range addresses simply wrap.
    assign off     = alu_res_in - BASE_ADDR;
    assign lo_addr = ADDR_W'(off >> 1) & ~ADDR_W'(1);
    assign hi_addr = lo_addr | ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_lo_d = rd_lo_q;
        rd_hi_d = rd_hi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end
            end
            ST_LO: begin
                if (phase_last) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    if (mem_r_en_in) begin
                        rd_lo_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HI: begin
                if (phase_last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (mem_r_en_in) begin
                        rd_hi_d = sram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        if ((state_q == ST_LO) || (state_q == ST_HI)) begin
            sram_addr = (state_q == ST_HI) ? hi_addr : lo_addr;
            if (is_store) begin
                sram_we_n  = 1'b0;
                sram_wdata = (state_q == ST_HI) ? val_rm_in[31:16] : val_rm_in[15:0];
            end else if (mem_r_en_in) begin
                sram_oe_n = 1'b0;
            end
        end
    end

    // While frozen, MEM/WB emits a bubble but keeps its data fields.
    always_comb begin
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        alu_res_d  = alu_res_q;
        mem_data_d = mem_data_q;
        dest_d     = dest_q;
        if (freeze) begin
            wb_en_d    = 1'b0;
            mem_r_en_d = 1'b0;
        end else begin
            wb_en_d    = wb_en_in;
            mem_r_en_d = mem_r_en_in;
            alu_res_d  = alu_res_in;
            mem_data_d = {rd_hi_q, rd_lo_q};
            dest_d     = dest_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rd_lo_q    <= '0;
            rd_hi_q    <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            dest_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_lo_q    <= rd_lo_d;
            rd_hi_q    <= rd_hi_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            alu_res_q  <= alu_res_d;
            mem_data_q <= mem_data_d;
            dest_q     <= dest_d;
        end
    end

    assign wb_en_out    = wb_en_q;
    assign mem_r_en_out = mem_r_en_q;
    assign alu_res_out  = alu_res_q;
    assign mem_data_out = mem_data_q;
    assign dest_out     = dest_q;

endmodule
